dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter IDX_BITS, default 5, cache index width (32 lines).
REQ-002 SHALL have parameter TAG_BITS, default 8, cache tag width.
REQ-003 SHALL have parameter NMSHR, default 4, outstanding-miss entries.
REQ-004 Address split, fixed: offset ld_addr[2:0] ignored; idx = ld_addr[IDX_BITS+2:3]; tag = ld_addr[IDX_BITS+TAG_BITS+2:IDX_BITS+3]; upper bits ignored; line = {tag,idx}.
REQ-005 clock  in  1  clock; all state on posedge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 ld_req  in  1  load request valid.
REQ-008 ld_addr  in  64  load byte address.
REQ-009 ld_stall  out  1  request not accepted this cycle; requester holds and retries.
REQ-010 ld_done  out  1  load data valid this cycle.
REQ-011 ld_done_addr  out  64  line address of completed load, {line,3'b0}, zero-extended.
REQ-012 ld_data  out  64  completed load data.
REQ-013 rd_idx / rd_tag  out  IDX_BITS / TAG_BITS  cache read port, driven from ld_addr.
REQ-014 rd_data / rd_valid  in  64 / 1  cache read result, same cycle.
REQ-015 wr_en, wr_idx, wr_tag, wr_data  out  1, IDX_BITS, TAG_BITS, 64  cache fill port; written at next edge.
REQ-016 proc2mem_command  out  2  0 NONE, 1 LOAD, 2 STORE (never driven).
REQ-017 proc2mem_addr  out  64  {line,3'b0}, zero-extended.
REQ-018 mem2proc_response  in  4  nonzero = request accepted, value is its transaction tag; 0 = rejected.
REQ-019 mem2proc_tag / mem2proc_data  in  4 / 64  returning transaction; tag 0 = none.

Function
REQ-020 Each MSHR entry SHALL hold state {INVALID, ISSUE, WAIT}, line, 4-bit mem tag.
REQ-021 Hit (ld_req, rd_valid, no fill this cycle): ld_done=1, ld_data=rd_data, ld_done_addr from ld_addr, same cycle, combinational; ld_stall=0.
REQ-022 Miss (ld_req, !rd_valid): if no entry holds same line and one is INVALID, lowest-index INVALID entry -> ISSUE at edge, ld_stall=0; else ld_stall=1, no allocation.
REQ-023 Issue: lowest-index ISSUE entry drives proc2mem_command=LOAD, proc2mem_addr; at most one command per cycle; none -> NONE, addr 0.
REQ-024 mem2proc_response!=0 during issue: entry -> WAIT, stores response as mem tag; response 0: entry stays ISSUE, reissued next cycle.
REQ-025 Fill: mem2proc_tag!=0 matching a WAIT entry tag: same cycle wr_en=1, wr_idx/wr_tag from entry line, wr_data=mem2proc_data; ld_done=1, ld_data=mem2proc_data, ld_done_addr=entry line; entry -> INVALID at edge.
REQ-026 Unmatched nonzero mem2proc_tag SHALL be ignored; no write, no ld_done.
REQ-027 Fill + ld_req same cycle: fill owns ld_done; request gets ld_stall=1 (hit or miss), no allocation.
REQ-028 Entry freed by fill not reallocated in the same cycle.
REQ-029 Line pending in an ISSUE or WAIT entry: request to that line stalls until filled; retry next cycle then hits.
REQ-030 Newly allocated entry issues no earlier than the cycle after allocation.
REQ-031 ld_req=0: ld_stall=0, no allocation.
REQ-032 Mem tags unique among WAIT entries (memory guarantee); controller does not check.

Reset
REQ-033 reset SHALL set all entries INVALID; outputs then: ld_stall=0, ld_done=0, ld_data=0, ld_done_addr=0, wr_en=0, proc2mem_command=NONE, proc2mem_addr=0.
REQ-034 Reset mid-operation drops outstanding misses; later responses for them ignored per REQ-026.
REQ-035 reset has priority over all same-edge events.

Verification
REQ-036 Hit: ld_req, ld_addr=0x108, rd_valid=1, rd_data=0xAB -> same cycle ld_done=1, ld_data=0xAB, ld_done_addr=0x108, ld_stall=0, command NONE.
REQ-037 Miss+fill: miss 0x200; next cycle LOAD 0x200, response 3; later mem2proc_tag=3, data 0x55 -> wr_en=1, wr_idx=0, wr_tag=0x02, ld_done=1, ld_data=0x55, ld_done_addr=0x200.
REQ-038 Retry: response 0 for two cycles, then 5 -> LOAD 0x200 on three consecutive cycles, entry WAIT with tag 5.
REQ-039 Full/merge: four misses to distinct lines -> fifth distinct miss and a repeat of line 0x200 both ld_stall=1; after one fill, fifth accepted next cycle.
REQ-040 Conflict: fill tag 3 and hit same cycle -> ld_done from fill, ld_stall=1; hit completes next cycle.
REQ-041 Reset: reset with two WAIT entries (tags 1,2), then mem2proc_tag=1 -> wr_en=0, ld_done=0.

Source files
------------

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - non-blocking load cache controller with MSHR-tracked misses
// Hits complete combinationally; misses queue in MSHRs, issue to memory and fill on tag match.
module dcache_ctrl #(
    parameter int IDX_BITS = 5,
    parameter int TAG_BITS = 8,
    parameter int NMSHR    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ld_req,
    input  logic [63:0]         ld_addr,
    output logic                ld_stall,
    output logic                ld_done,
    output logic [63:0]         ld_done_addr,
    output logic [63:0]         ld_data,
    output logic [IDX_BITS-1:0] rd_idx,
    output logic [TAG_BITS-1:0] rd_tag,
    input  logic [63:0]         rd_data,
    input  logic                rd_valid,
    output logic                wr_en,
    output logic [IDX_BITS-1:0] wr_idx,
    output logic [TAG_BITS-1:0] wr_tag,
    output logic [63:0]         wr_data,
    output logic [1:0]          proc2mem_command,
    output logic [63:0]         proc2mem_addr,
    input  logic [3:0]          mem2proc_response,
    input  logic [3:0]          mem2proc_tag,
    input  logic [63:0]         mem2proc_data
);

    localparam int LW = IDX_BITS + TAG_BITS;
    localparam int MW = (NMSHR > 1) ? $clog2(NMSHR) : 1;

    typedef enum logic [1:0] {ST_INVALID, ST_ISSUE, ST_WAIT} mshr_state_t;

    mshr_state_t   r_state [NMSHR];
    logic [LW-1:0] r_line  [NMSHR];
    logic [3:0]    r_mtag  [NMSHR];

    logic [LW-1:0] w_line;
    logic          w_fill_hit, w_iss_any, w_free_any, w_pending;
    logic [MW-1:0] w_fill_sel, w_iss_sel, w_free_sel;
    logic          w_hit, w_alloc;
    logic          w_unused_addr_bits;

    assign w_line             = ld_addr[LW+2:3];
    assign w_unused_addr_bits = ^{ld_addr[63:LW+3], ld_addr[2:0]};
    assign rd_idx             = w_line[IDX_BITS-1:0];
    assign rd_tag             = w_line[LW-1:IDX_BITS];

    // Descending scans leave the lowest matching index selected.
    always_comb begin
        w_fill_hit = 1'b0;
        w_fill_sel = '0;
        w_iss_any  = 1'b0;
        w_iss_sel  = '0;
        w_free_any = 1'b0;
        w_free_sel = '0;
        w_pending  = 1'b0;
        for (int i = NMSHR - 1; i >= 0; i--) begin
            if (r_state[i] == ST_WAIT && mem2proc_tag != 4'd0 && r_mtag[i] == mem2proc_tag) begin
                w_fill_hit = 1'b1;
                w_fill_sel = MW'(i);
            end
            if (r_state[i] == ST_ISSUE) begin
                w_iss_any = 1'b1;
                w_iss_sel = MW'(i);
            end
            if (r_state[i] == ST_INVALID) begin
                w_free_any = 1'b1;
                w_free_sel = MW'(i);
            end
            if (r_state[i] != ST_INVALID && r_line[i] == w_line) begin
                w_pending = 1'b1;
            end
        end
    end

    // A fill owns the completion port, so any concurrent request must retry.
    assign w_hit    = ld_req && rd_valid && !w_fill_hit;
    assign w_alloc  = ld_req && !rd_valid && !w_fill_hit && !w_pending && w_free_any;
    assign ld_stall = ld_req && !w_hit && !w_alloc;

    assign wr_en   = w_fill_hit;
    assign wr_idx  = r_line[w_fill_sel][IDX_BITS-1:0];
    assign wr_tag  = r_line[w_fill_sel][LW-1:IDX_BITS];
    assign wr_data = mem2proc_data;

    assign ld_done      = w_fill_hit || w_hit;
    assign ld_data      = w_fill_hit ? mem2proc_data : (w_hit ? rd_data : 64'd0);
    assign ld_done_addr = w_fill_hit ? {{(61-LW){1'b0}}, r_line[w_fill_sel], 3'b000} :
                          w_hit      ? {{(61-LW){1'b0}}, w_line, 3'b000} : 64'd0;

    assign proc2mem_command = w_iss_any ? 2'd1 : 2'd0;
    assign proc2mem_addr    = w_iss_any ? {{(61-LW){1'b0}}, r_line[w_iss_sel], 3'b000} : 64'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NMSHR; i++) begin
                r_state[i] <= ST_INVALID;
            end
        end else begin
            if (w_fill_hit) begin
                r_state[w_fill_sel] <= ST_INVALID;
            end
            if (w_iss_any && mem2proc_response != 4'd0) begin
                r_state[w_iss_sel] <= ST_WAIT;
                r_mtag[w_iss_sel]  <= mem2proc_response;
            end
            if (w_alloc) begin
                r_state[w_free_sel] <= ST_ISSUE;
                r_line[w_free_sel]  <= w_line;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

    logic        clock;
    logic        reset;
    logic        ld_req;
    logic [63:0] ld_addr;
    logic        ld_stall, ld_done;
    logic [63:0] ld_done_addr, ld_data;
    logic [4:0]  rd_idx;
    logic [7:0]  rd_tag;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [7:0]  wr_tag;
    logic [63:0] wr_data;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [63:0] mem2proc_data;

    int checks = 0;
    int fails  = 0;

    dcache_ctrl #(.IDX_BITS(5), .TAG_BITS(8), .NMSHR(4)) dut (
        .clock(clock), .reset(reset), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_stall(ld_stall), .ld_done(ld_done), .ld_done_addr(ld_done_addr), .ld_data(ld_data),
        .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag), .wr_data(wr_data),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
        .mem2proc_data(mem2proc_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one cycle of inputs just after the falling edge, then settle.
    task automatic cyc(input logic req, input logic [63:0] addr, input logic rv,
                       input logic [63:0] rdat, input logic [3:0] resp,
                       input logic [3:0] mtag, input logic [63:0] mdat);
        @(negedge clock);
        ld_req = req; ld_addr = addr; rd_valid = rv; rd_data = rdat;
        mem2proc_response = resp; mem2proc_tag = mtag; mem2proc_data = mdat;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        ld_req = 0; ld_addr = 0; rd_valid = 0; rd_data = 0;
        mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (ld_stall !== 1'b0) begin fails++; $display("FAIL rst_stall got=%0h exp=0", ld_stall); end
        checks++; if (ld_done !== 1'b0) begin fails++; $display("FAIL rst_done got=%0h exp=0", ld_done); end
        checks++; if (ld_data !== 64'd0) begin fails++; $display("FAIL rst_data got=%0h exp=0", ld_data); end
        checks++; if (ld_done_addr !== 64'd0) begin fails++; $display("FAIL rst_daddr got=%0h exp=0", ld_done_addr); end
        checks++; if (wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en got=%0h exp=0", wr_en); end
        checks++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL rst_cmd got=%0h exp=0", proc2mem_command); end
        checks++; if (proc2mem_addr !== 64'd0) begin fails++; $display("FAIL rst_maddr got=%0h exp=0", proc2mem_addr); end
    endtask

    task automatic test_hit();
        cyc(1, 64'h108, 1, 64'hAB, 0, 0, 0);
        checks++; if (ld_done !== 1'b1) begin fails++; $display("FAIL hit_done got=%0h exp=1", ld_done); end
        checks++; if (ld_data !== 64'hAB) begin fails++; $display("FAIL hit_data got=%0h exp=ab", ld_data); end
        checks++; if (ld_done_addr !== 64'h108) begin fails++; $display("FAIL hit_daddr got=%0h exp=108", ld_done_addr); end
        checks++; if (ld_stall !== 1'b0) begin fails++; $display("FAIL hit_stall got=%0h exp=0", ld_stall); end
        checks++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL hit_cmd got=%0h exp=0", proc2mem_command); end
        checks++; if (rd_idx !== 5'd1 || rd_tag !== 8'd1) begin fails++; $display("FAIL hit_rdport got=%0h/%0h exp=1/1", rd_idx, rd_tag); end
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_miss_fill();
        do_reset();
        cyc(1, 64'h200, 0, 0, 0, 0, 0);
        checks++; if (ld_stall !== 1'b0) begin fails++; $display("FAIL mf_alloc_stall got=%0h exp=0", ld_stall); end
        checks++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL mf_alloc_cmd got=%0h exp=0", proc2mem_command); end
        cyc(0, 0, 0, 0, 4'd3, 0, 0);
        checks++; if (proc2mem_command !== 2'd1) begin fails++; $display("FAIL mf_issue_cmd got=%0h exp=1", proc2mem_command); end
        checks++; if (proc2mem_addr !== 64'h200) begin fails++; $display("FAIL mf_issue_addr got=%0h exp=200", proc2mem_addr); end
        cyc(1, 64'h200, 0, 0, 0, 0, 0);
        checks++; if (ld_stall !== 1'b1) begin fails++; $display("FAIL mf_pending_stall got=%0h exp=1", ld_stall); end
        checks++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL mf_wait_cmd got=%0h exp=0", proc2mem_command); end
        cyc(0, 0, 0, 0, 0, 4'd3, 64'h55);
        checks++; if (wr_en !== 1'b1) begin fails++; $display("FAIL mf_wr_en got=%0h exp=1", wr_en); end
        checks++; if (wr_idx !== 5'd0 || wr_tag !== 8'h02) begin fails++; $display("FAIL mf_wr_line got=%0h/%0h exp=0/2", wr_idx, wr_tag); end
        checks++; if (wr_data !== 64'h55) begin fails++; $display("FAIL mf_wr_data got=%0h exp=55", wr_data); end
        checks++; if (ld_done !== 1'b1 || ld_data !== 64'h55) begin fails++; $display("FAIL mf_done got=%0h/%0h exp=1/55", ld_done, ld_data); end
        checks++; if (ld_done_addr !== 64'h200) begin fails++; $display("FAIL mf_daddr got=%0h exp=200", ld_done_addr); end
        cyc(0, 0, 0, 0, 0, 4'd3, 64'h66);
        checks++; if (wr_en !== 1'b0 || ld_done !== 1'b0) begin fails++; $display("FAIL mf_stale_tag got=%0h/%0h exp=0/0", wr_en, ld_done); end
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_retry();
        do_reset();
        cyc(1, 64'h200, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 4'd0, 0, 0);
        checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h200) begin fails++; $display("FAIL rt_issue1 got=%0h/%0h exp=1/200", proc2mem_command, proc2mem_addr); end
        cyc(0, 0, 0, 0, 4'd0, 0, 0);
        checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h200) begin fails++; $display("FAIL rt_issue2 got=%0h/%0h exp=1/200", proc2mem_command, proc2mem_addr); end
        cyc(0, 0, 0, 0, 4'd5, 0, 0);
        checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h200) begin fails++; $display("FAIL rt_issue3 got=%0h/%0h exp=1/200", proc2mem_command, proc2mem_addr); end
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL rt_waiting_cmd got=%0h exp=0", proc2mem_command); end
        cyc(0, 0, 0, 0, 0, 4'd5, 64'h77);
        checks++; if (wr_en !== 1'b1 || ld_data !== 64'h77) begin fails++; $display("FAIL rt_fill got=%0h/%0h exp=1/77", wr_en, ld_data); end
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_full_merge();
        logic [63:0] exp_addr;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1, 64'h200 + 64'(k * 8), 0, 0, 0, 0, 0);
            checks++; if (ld_stall !== 1'b0) begin fails++; $display("FAIL fm_alloc%0d_stall got=%0h exp=0", k, ld_stall); end
        end
        cyc(1, 64'h220, 0, 0, 0, 0, 0);
        checks++; if (ld_stall !== 1'b1) begin fails++; $display("FAIL fm_full_stall got=%0h exp=1", ld_stall); end
        cyc(1, 64'h200, 0, 0, 0, 0, 0);
        checks++; if (ld_stall !== 1'b1) begin fails++; $display("FAIL fm_merge_stall got=%0h exp=1", ld_stall); end
        for (int k = 0; k < 4; k++) begin
            exp_addr = 64'h200 + 64'(k * 8);
            cyc(0, 0, 0, 0, 4'(k + 1), 0, 0);
            checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== exp_addr) begin fails++; $display("FAIL fm_issue%0d got=%0h/%0h exp=1/%0h", k, proc2mem_command, proc2mem_addr, exp_addr); end
        end
        cyc(1, 64'h220, 0, 0, 0, 4'd2, 64'h88);
        checks++; if (ld_done !== 1'b1 || ld_done_addr !== 64'h208) begin fails++; $display("FAIL fm_fill got=%0h/%0h exp=1/208", ld_done, ld_done_addr); end
        checks++; if (ld_stall !== 1'b1) begin fails++; $display("FAIL fm_fill_stall got=%0h exp=1", ld_stall); end
        cyc(1, 64'h220, 0, 0, 0, 0, 0);
        checks++; if (ld_stall !== 1'b0) begin fails++; $display("FAIL fm_realloc_stall got=%0h exp=0", ld_stall); end
        cyc(0, 0, 0, 0, 0, 0, 0);
        checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h220) begin fails++; $display("FAIL fm_realloc_issue got=%0h/%0h exp=1/220", proc2mem_command, proc2mem_addr); end
    endtask

    task automatic test_conflict();
        do_reset();
        cyc(1, 64'h200, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 4'd3, 0, 0);
        cyc(1, 64'h108, 1, 64'hAB, 0, 4'd3, 64'h55);
        checks++; if (ld_done !== 1'b1 || ld_data !== 64'h55 || ld_done_addr !== 64'h200) begin fails++; $display("FAIL cf_fill got=%0h/%0h/%0h exp=1/55/200", ld_done, ld_data, ld_done_addr); end
        checks++; if (ld_stall !== 1'b1) begin fails++; $display("FAIL cf_stall got=%0h exp=1", ld_stall); end
        cyc(1, 64'h108, 1, 64'hAB, 0, 0, 0);
        checks++; if (ld_done !== 1'b1 || ld_data !== 64'hAB || ld_done_addr !== 64'h108) begin fails++; $display("FAIL cf_hit got=%0h/%0h/%0h exp=1/ab/108", ld_done, ld_data, ld_done_addr); end
        checks++; if (ld_stall !== 1'b0) begin fails++; $display("FAIL cf_hit_stall got=%0h exp=0", ld_stall); end
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1, 64'h200, 0, 0, 0, 0, 0);
        cyc(1, 64'h208, 0, 0, 4'd1, 0, 0);
        cyc(0, 0, 0, 0, 4'd2, 0, 0);
        checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h208) begin fails++; $display("FAIL rm_issue got=%0h/%0h exp=1/208", proc2mem_command, proc2mem_addr); end
        do_reset();
        cyc(0, 0, 0, 0, 0, 4'd1, 64'h99);
        checks++; if (wr_en !== 1'b0 || ld_done !== 1'b0) begin fails++; $display("FAIL rm_tag1 got=%0h/%0h exp=0/0", wr_en, ld_done); end
        cyc(0, 0, 0, 0, 0, 4'd2, 64'h99);
        checks++; if (wr_en !== 1'b0 || ld_done !== 1'b0) begin fails++; $display("FAIL rm_tag2 got=%0h/%0h exp=0/0", wr_en, ld_done); end
        checks++; if (proc2mem_command !== 2'd0) begin fails++; $display("FAIL rm_cmd got=%0h exp=0", proc2mem_command); end
    endtask

    initial begin
        reset = 1'b1;
        ld_req = 0; ld_addr = 0; rd_valid = 0; rd_data = 0;
        mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
        test_reset();
        test_hit();
        test_miss_fill();
        test_retry();
        test_full_merge();
        test_conflict();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
